// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one NOT/AND/OR/XOR unit among NUM_REQ requesters.
// Define LU_ARB_FIXED_PRIO_EN to get lowest-index-wins fixed priority instead.
module logic_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [2*NUM_REQ-1:0]     op,
   input  logic [WIDTH*NUM_REQ-1:0] a,
   input  logic [WIDTH*NUM_REQ-1:0] b,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       done,
   output logic [WIDTH-1:0]         result,
   output logic                     busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   cand_idx;
   logic               win_vld;
`ifndef LU_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   win_q, win_d;
`endif

   function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (f)
         2'b00:   r = ~x;
         2'b01:   r = x & y;
         2'b10:   r = x | y;
         default: r = x ^ y;
      endcase
      return r;
   endfunction

   // Winner search; iterating from the far end lets the nearest candidate overwrite.
   always_comb begin
      win      = '0;
      cand_idx = '0;
      win_vld  = 1'b0;
`ifdef LU_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         cand_idx = IDX_W'(i);
         if (req[cand_idx]) begin
            win     = cand_idx;
            win_vld = 1'b1;
         end
      end
`else
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (req[cand_idx]) begin
            win     = cand_idx;
            win_vld = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = done_q;
      result_d = result_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
`ifndef LU_ARB_FIXED_PRIO_EN
      last_d   = last_q;
      win_d    = win_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               gnt_d   = NUM_REQ'(1) << win;
               op_d    = op[2*int'(win) +: 2];
               a_d     = a[WIDTH*int'(win) +: WIDTH];
               b_d     = b[WIDTH*int'(win) +: WIDTH];
               state_d = EXEC;
`ifndef LU_ARB_FIXED_PRIO_EN
               win_d   = win;
`endif
            end
         end
         EXEC: begin
            result_d = lu_eval(op_q, a_q, b_q);
            done_d   = gnt_q;
            state_d  = DONE;
         end
         DONE: begin
            done_d  = '0;
            gnt_d   = '0;
            state_d = IDLE;
`ifndef LU_ARB_FIXED_PRIO_EN
            last_d  = win_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
`ifndef LU_ARB_FIXED_PRIO_EN
         last_q   <= IDX_W'(NUM_REQ-1);
         win_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
`ifndef LU_ARB_FIXED_PRIO_EN
         last_q   <= last_d;
         win_q    <= win_d;
`endif
      end
   end

   // Operand latches carry no control meaning, so they skip reset.
   always_ff @(posedge clk) begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign result = result_q;
   assign busy   = (state_q != IDLE);

endmodule
